// File: rtl/l2_infer.sv
// Two-channel trace-based spiking classifier: decaying input traces feed four
// weighted-sum neurons evaluated one per clock, and the strongest neuron over threshold fires.
module l2_infer #(
   parameter int                 p_width      = 9,
   parameter logic [p_width-1:0] p_ts_max     = {p_width{1'b1}},
   parameter int                 p_decay_step = 1,
   parameter int                 p_spike_clks = 2
) (
   input  logic                         i_clk,
   input  logic                         i_rst_n,
   input  logic [2:1]                   i_event,
   input  logic [4*(2*p_width)-1:0]     i_weights,
   input  logic [4*(2*p_width+1)-1:0]   i_thresholds,
   output logic [4:1]                   o_spikeout,
   output logic [2*p_width-1:0]         o_ts,
   output logic [4*(2*p_width+1)-1:0]   o_lv
);

   localparam int lw = 2*p_width + 1;
   localparam int hw = $clog2(p_spike_clks + 1);
   localparam logic [p_width-1:0] decay_c  = p_width'(p_decay_step);
   localparam logic [hw-1:0]      hold_max = hw'(p_spike_clks);

   localparam logic [1:0] st_idle   = 2'd0;
   localparam logic [1:0] st_calc   = 2'd1;
   localparam logic [1:0] st_decide = 2'd2;
   localparam logic [1:0] st_fire   = 2'd3;

   genvar gi;

   logic [1:0]            state_reg;
   logic [1:0]            idx_reg;
   logic                  pending_reg;
   logic [hw-1:0]         hold_reg;
   logic [3:0]            spike_reg;
   logic [2*p_width-1:0]  ts_reg;
   logic [lw-1:0]         lv_reg [0:3];

   logic [p_width-1:0]    trace_next [1:2];
   logic [p_width-1:0]    w1_arr [0:3];
   logic [p_width-1:0]    w2_arr [0:3];
   logic [lw-1:0]         thr_arr [0:3];
   logic [3:0]            cand;

   // Traces keep running regardless of FSM state so the snapshot always sees fresh values.
   for (gi = 1; gi <= 2; gi++) begin : g_trace
      logic [p_width-1:0] trace_reg;
      assign trace_next[gi] = i_event[gi]          ? p_ts_max :
                              (trace_reg > decay_c) ? trace_reg - decay_c : '0;
      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) trace_reg <= '0;
         else          trace_reg <= trace_next[gi];
      end
   end

   for (gi = 0; gi < 4; gi++) begin : g_neuron
      assign w1_arr[gi]  = i_weights[gi*2*p_width +: p_width];
      assign w2_arr[gi]  = i_weights[gi*2*p_width + p_width +: p_width];
      assign thr_arr[gi] = i_thresholds[gi*lw +: lw];
      assign cand[gi]    = lv_reg[gi] >= thr_arr[gi];
      assign o_lv[gi*lw +: lw] = lv_reg[gi];
   end

   // Zero-extended operands keep the full product; the extra sum bit absorbs the carry.
   logic [2*p_width-1:0] prod1, prod2;
   logic [lw-1:0]        mac;
   assign prod1 = {{p_width{1'b0}}, w1_arr[idx_reg]} * {{p_width{1'b0}}, ts_reg[p_width-1:0]};
   assign prod2 = {{p_width{1'b0}}, w2_arr[idx_reg]} * {{p_width{1'b0}}, ts_reg[2*p_width-1:p_width]};
   assign mac   = {1'b0, prod1} + {1'b0, prod2};

   logic          win_found;
   logic [1:0]    win_idx;
   logic [lw-1:0] win_lv;
   logic [3:0]    win_onehot;

   // Strict greater-than keeps the lowest index on ties.
   always_comb begin
      win_found = 1'b0;
      win_idx   = 2'd0;
      win_lv    = '0;
      for (int n = 0; n < 4; n++) begin
         if (cand[n] && (!win_found || lv_reg[n] > win_lv)) begin
            win_found = 1'b1;
            win_idx   = 2'(n);
            win_lv    = lv_reg[n];
         end
      end
   end
   assign win_onehot = 4'b0001 << win_idx;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_reg   <= st_idle;
         idx_reg     <= 2'd0;
         pending_reg <= 1'b0;
         hold_reg    <= '0;
         spike_reg   <= 4'd0;
         ts_reg      <= '0;
         for (int n = 0; n < 4; n++) lv_reg[n] <= '0;
      end else begin
         if (state_reg != st_idle && |i_event) pending_reg <= 1'b1;
         case (state_reg)
            st_idle: begin
               if (|i_event || pending_reg) begin
                  state_reg   <= st_calc;
                  idx_reg     <= 2'd0;
                  pending_reg <= 1'b0;
                  ts_reg      <= {trace_next[2], trace_next[1]};
               end
            end
            st_calc: begin
               lv_reg[idx_reg] <= mac;
               idx_reg         <= idx_reg + 2'd1;
               if (idx_reg == 2'd3) state_reg <= st_decide;
            end
            st_decide: begin
               if (win_found) begin
                  spike_reg <= win_onehot;
                  hold_reg  <= hw'(1);
                  state_reg <= st_fire;
               end else begin
                  state_reg <= st_idle;
               end
            end
            default: begin
               if (hold_reg >= hold_max) begin
                  spike_reg <= 4'd0;
                  hold_reg  <= '0;
                  state_reg <= st_idle;
               end else begin
                  hold_reg  <= hold_reg + hw'(1);
               end
            end
         endcase
      end
   end

   assign o_spikeout = spike_reg;
   assign o_ts       = ts_reg;

endmodule
